// File: rtl/gencon_pkg.sv
// gencon_pkg: shared types and helpers for the gencon calculator controller.
//   state_t      : FSM state encoding (also driven onto tb_current_state)
//   OP_*         : keypad operator level codes
//   ALU_*        : compact 2-bit operation latched for the ALU
//   MAX_MAG      : largest displayable magnitude
//   accumulate   : decimal digit accumulation with entry clamp
//   entry_display: sign-magnitude view of an operand being entered
package gencon_pkg;

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    OP_LATCH = 3'd1,
    CLEAR_B  = 3'd2,
    ENTER_B  = 3'd3,
    COMPUTE  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_NEG  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_MUL = 2'd2;

  localparam int MAX_MAG = 32767;

  // Entry magnitudes stop at 32768 so that -32768 is reachable; a positive
  // operand of 32768 is later treated as 32767.
  localparam logic [16:0] ENTRY_CLAMP = 17'd32768;

  function automatic logic [16:0] accumulate(input logic [16:0] mag,
                                             input logic [3:0]  digit);
    logic [20:0] wide;
    wide = {4'd0, mag} * 21'd10 + {17'd0, digit};
    if (wide > {4'd0, ENTRY_CLAMP}) begin
      return ENTRY_CLAMP;
    end
    return wide[16:0];
  endfunction

  // A clamped magnitude of 32768 cannot fit 15 bits; show it as 0x7FFF.
  function automatic logic [15:0] entry_display(input logic        sign,
                                                input logic [16:0] mag);
    if (mag >= ENTRY_CLAMP) begin
      return {sign, 15'h7FFF};
    end
    return {sign, mag[14:0]};
  endfunction

  function automatic logic [1:0] to_alu_op(input logic [2:0] code);
    case (code)
      OP_SUB:  return ALU_SUB;
      OP_MUL:  return ALU_MUL;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/gencon_alu.sv
// gencon_alu: combinational signed add/subtract/multiply of two
// sign-magnitude operands, saturated to +/-MAX_MAG, sign-magnitude result.
//   op     in  2   ALU_ADD / ALU_SUB / ALU_MUL
//   sign_a in  1   operand A sign
//   mag_a  in  17  operand A magnitude (0..32768)
//   sign_b in  1   operand B sign
//   mag_b  in  17  operand B magnitude (0..32768)
//   result out 16  {sign, magnitude[14:0]}; zero is always +0
module gencon_alu
  import gencon_pkg::*;
(
  input  logic [1:0]  op,
  input  logic        sign_a,
  input  logic [16:0] mag_a,
  input  logic        sign_b,
  input  logic [16:0] mag_b,
  output logic [15:0] result
);

  logic signed [31:0] val_a;
  logic signed [31:0] val_b;
  logic signed [31:0] raw;

  // Negative operands may reach -32768; positive ones cap at +32767.
  function automatic logic signed [31:0] operand(input logic        sign,
                                                 input logic [16:0] mag);
    if (sign) begin
      return -$signed({15'd0, mag});
    end
    if (mag > 17'd32767) begin
      return 32'sd32767;
    end
    return $signed({15'd0, mag});
  endfunction

  always_comb begin
    val_a = operand(sign_a, mag_a);
    val_b = operand(sign_b, mag_b);
    case (op)
      ALU_ADD: raw = val_a + val_b;
      ALU_SUB: raw = val_a - val_b;
      default: raw = val_a * val_b;  // |product| <= 2^30, fits 32 bits
    endcase

    if (raw > 32'sd32767) begin
      result = {1'b0, 15'h7FFF};
    end else if (raw < -32'sd32767) begin
      result = {1'b1, 15'h7FFF};
    end else if (raw < 0) begin
      result = {1'b1, 15'(-raw)};
    end else begin
      result = {1'b0, raw[14:0]};
    end
  end

endmodule

// File: rtl/gencon.sv
// gencon: sign-magnitude 16-bit calculator controller.
//   clk              in  1   rising-edge clock
//   nRST             in  1   synchronous active-low reset
//   keypad_input     in  4   digit 0-9, valid with read_input
//   read_input       in  1   one-cycle digit strobe
//   operator_input   in  3   level operator code (OP_*)
//   equal_input      in  1   compute request, level-sampled in ENTER_B
//   complete         out 1   one-cycle pulse in DONE, result valid
//   display_output   out 16  sign-magnitude display bus
//   tb_current_state out 3   current FSM state (state_t)
//
// Handshake: read_input is a single-cycle valid strobe with no ready; a
// digit is consumed on the edge where read_input=1 only in ENTER_A/ENTER_B,
// otherwise it is dropped. A digit strobe masks any operator code in the
// same cycle. complete is a single-cycle valid with no ready: the consumer
// must take display_output in the cycle complete=1 (it also holds after).
module gencon
  import gencon_pkg::*;
(
  input  logic        clk,
  input  logic        nRST,
  input  logic [3:0]  keypad_input,
  input  logic        read_input,
  input  logic [2:0]  operator_input,
  input  logic        equal_input,
  output logic        complete,
  output logic [15:0] display_output,
  output logic [2:0]  tb_current_state
);

  state_t      state_q;
  state_t      state_d;
  logic [16:0] opA_mag;
  logic [16:0] opB_mag;
  logic        signA;
  logic        signB;
  logic [1:0]  op;
  logic [15:0] result;
  logic [15:0] alu_result;
  // Set after reset/DONE: the next entry action on A starts a new operand
  // and the display keeps showing the previous result until then.
  logic        fresh;

  logic digit_ok;
  logic toggle;
  logic op_req;

  assign digit_ok = read_input && (keypad_input <= 4'd9);
  assign toggle   = !read_input && (operator_input == OP_NEG);
  assign op_req   = !read_input && ((operator_input == OP_ADD) ||
                                    (operator_input == OP_SUB) ||
                                    (operator_input == OP_MUL));

  assign tb_current_state = state_q;

  gencon_alu u_alu (
    .op     (op),
    .sign_a (signA),
    .mag_a  (opA_mag),
    .sign_b (signB),
    .mag_b  (opB_mag),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q <= ENTER_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    complete       = 1'b0;
    display_output = result;
    case (state_q)
      ENTER_A: begin
        if (op_req) begin
          state_d = OP_LATCH;
        end
        if (!fresh) begin
          display_output = entry_display(signA, opA_mag);
        end
      end
      OP_LATCH: begin
        state_d        = CLEAR_B;
        display_output = entry_display(signA, opA_mag);
      end
      CLEAR_B: begin
        state_d        = ENTER_B;
        display_output = entry_display(signA, opA_mag);
      end
      ENTER_B: begin
        if (equal_input) begin
          state_d = COMPUTE;
        end
        display_output = entry_display(signB, opB_mag);
      end
      COMPUTE: begin
        state_d        = DONE;
        display_output = entry_display(signB, opB_mag);
      end
      DONE: begin
        state_d  = ENTER_A;
        complete = 1'b1;
      end
      default: begin
        state_d = ENTER_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      opA_mag <= '0;
      opB_mag <= '0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      op      <= ALU_ADD;
      result  <= '0;
      fresh   <= 1'b1;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (digit_ok) begin
            opA_mag <= accumulate(fresh ? 17'd0 : opA_mag, keypad_input);
            if (fresh) begin
              signA <= 1'b0;
            end
            fresh <= 1'b0;
          end else if (toggle) begin
            // A toggle also starts a new operand, so "-, 2, 5" gives -25.
            if (fresh) begin
              opA_mag <= '0;
              signA   <= 1'b1;
            end else begin
              signA <= ~signA;
            end
            fresh <= 1'b0;
          end else if (op_req) begin
            op <= to_alu_op(operator_input);
          end
        end
        CLEAR_B: begin
          opB_mag <= '0;
          signB   <= 1'b0;
        end
        ENTER_B: begin
          if (digit_ok) begin
            opB_mag <= accumulate(opB_mag, keypad_input);
          end else if (toggle) begin
            signB <= ~signB;
          end
        end
        COMPUTE: begin
          result <= alu_result;
        end
        DONE: begin
          fresh <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gencon.sv
// tb_gencon: table-driven and randomized checks of the gencon calculator
// against an integer-arithmetic reference model.
module tb_gencon;

  localparam logic [2:0] C_NEG = 3'b001;
  localparam logic [2:0] C_ADD = 3'b010;
  localparam logic [2:0] C_SUB = 3'b011;
  localparam logic [2:0] C_MUL = 3'b100;
  localparam logic [2:0] S_ENTER_A = 3'd0;
  localparam logic [2:0] S_ENTER_B = 3'd3;

  logic        clk;
  logic        nRST;
  logic [3:0]  keypad_input;
  logic        read_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        complete;
  logic [15:0] display_output;
  logic [2:0]  tb_current_state;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  gencon dut (
    .clk              (clk),
    .nRST             (nRST),
    .keypad_input     (keypad_input),
    .read_input       (read_input),
    .operator_input   (operator_input),
    .equal_input      (equal_input),
    .complete         (complete),
    .display_output   (display_output),
    .tb_current_state (tb_current_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic int operand_val(input int unsigned n, input bit neg);
    int unsigned m;
    m = (n > 32768) ? 32768 : n;
    if (neg) return -int'(m);
    return (m > 32767) ? 32767 : int'(m);
  endfunction

  function automatic logic [15:0] model_result(input int a, input int b,
                                               input logic [2:0] code);
    longint r;
    case (code)
      C_ADD:   r = longint'(a) + longint'(b);
      C_SUB:   r = longint'(a) - longint'(b);
      default: r = longint'(a) * longint'(b);
    endcase
    if (r > 32767)  r = 32767;
    if (r < -32767) r = -32767;
    if (r < 0) return {1'b1, 15'(-r)};
    return {1'b0, 15'(r)};
  endfunction

  function automatic logic [15:0] model_entry(input int unsigned n, input bit neg);
    int unsigned m;
    m = (n > 32768) ? 32768 : n;
    return {neg, (m > 32767) ? 15'h7FFF : 15'(m)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic press_digit(input logic [3:0] d);
    keypad_input = d;
    read_input   = 1'b1;
    tick();
    read_input   = 1'b0;
  endtask

  task automatic press_op(input logic [2:0] c);
    operator_input = c;
    tick();
    operator_input = 3'b000;
  endtask

  task automatic enter_number(input int unsigned n, input int toggles);
    int dg[10];
    int nd;
    int unsigned t;
    for (int i = 0; i < toggles; i++) press_op(C_NEG);
    nd = 0;
    t  = n;
    if (t == 0) begin
      dg[0] = 0;
      nd    = 1;
    end
    while (t != 0) begin
      dg[nd] = int'(t % 10);
      t      = t / 10;
      nd++;
    end
    for (int i = nd - 1; i >= 0; i--) press_digit(4'(dg[i]));
  endtask

  // Wait (bounded) for ENTER_B; optionally inject digits that must be dropped.
  task automatic wait_enter_b(input bit junk, output int cyc);
    cyc = 1;
    while (tb_current_state != S_ENTER_B && cyc < 8) begin
      if (junk) begin
        keypad_input = 4'd7;
        read_input   = 1'b1;
      end
      tick();
      read_input = 1'b0;
      cyc++;
    end
  endtask

  task automatic run_calc(input string tag, input int unsigned a_n,
                          input int a_tog, input logic [2:0] code,
                          input int unsigned b_n, input int b_tog,
                          input bit junk, input logic [15:0] exp);
    int cyc;
    bit a_neg;
    bit b_neg;
    logic [15:0] want;
    a_neg = (a_tog % 2) == 1;
    b_neg = (b_tog % 2) == 1;
    exp_q.push_back(exp);
    enter_number(a_n, a_tog);
    check({tag, " a_disp"}, {16'd0, display_output}, {16'd0, model_entry(a_n, a_neg)});
    press_op(code);
    wait_enter_b(junk, cyc);
    check({tag, " b_latency"}, cyc, 3);
    enter_number(b_n, b_tog);
    check({tag, " b_disp"}, {16'd0, display_output}, {16'd0, model_entry(b_n, b_neg)});
    equal_input = 1'b1;
    tick();
    equal_input = 1'b0;
    cyc = 1;
    while (!complete && cyc < 8) begin
      tick();
      cyc++;
    end
    want = exp_q.pop_front();
    check({tag, " complete_seen"}, {31'd0, complete}, 1);
    check({tag, " eq_latency"}, cyc, 2);
    check({tag, " result"}, {16'd0, display_output}, {16'd0, want});
    tick();
    check({tag, " pulse_width"}, {31'd0, complete}, 0);
    check({tag, " back_to_a"}, {29'd0, tb_current_state}, {29'd0, S_ENTER_A});
    check({tag, " hold"}, {16'd0, display_output}, {16'd0, want});
  endtask

  typedef struct {
    int unsigned a_n;
    int          a_tog;
    logic [2:0]  code;
    int unsigned b_n;
    int          b_tog;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int cyc;
    vecs[0]  = '{25,    1, C_ADD, 15,    1, 16'h8028};
    vecs[1]  = '{2,     0, C_ADD, 3,     0, 16'h0005};
    vecs[2]  = '{1000,  0, C_ADD, 2345,  0, 16'h0D11};
    vecs[3]  = '{0,     0, C_ADD, 0,     0, 16'h0000};
    vecs[4]  = '{5,     0, C_SUB, 3,     0, 16'h0002};
    vecs[5]  = '{3,     0, C_SUB, 5,     0, 16'h8002};
    vecs[6]  = '{3,     1, C_SUB, 5,     1, 16'h0002};
    vecs[7]  = '{3,     1, C_MUL, 6,     1, 16'h0012};
    vecs[8]  = '{128,   0, C_MUL, 256,   0, 16'h7FFF};
    vecs[9]  = '{12,    1, C_MUL, 3000,  0, 16'hFFFF};
    vecs[10] = '{32768, 1, C_ADD, 32767, 0, 16'h8001};
    vecs[11] = '{99999, 0, C_ADD, 0,     0, 16'h7FFF};

    nRST           = 1'b0;
    keypad_input   = 4'd0;
    read_input     = 1'b0;
    operator_input = 3'b000;
    equal_input    = 1'b0;
    tick();
    tick();
    check("reset state", {29'd0, tb_current_state}, 0);
    check("reset display", {16'd0, display_output}, 0);
    check("reset complete", {31'd0, complete}, 0);
    nRST = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_calc($sformatf("vec%0d", i), vecs[i].a_n, vecs[i].a_tog, vecs[i].code,
               vecs[i].b_n, vecs[i].b_tog, bit'(i % 2), vecs[i].exp);
    end

    // Reset in the middle of operand B aborts everything.
    enter_number(7, 0);
    press_op(C_ADD);
    wait_enter_b(1'b0, cyc);
    press_digit(4'd1);
    press_digit(4'd2);
    nRST = 1'b0;
    tick();
    check("midb_reset state", {29'd0, tb_current_state}, 0);
    check("midb_reset display", {16'd0, display_output}, 0);
    check("midb_reset complete", {31'd0, complete}, 0);
    nRST = 1'b1;
    tick();
    run_calc("after_reset", 4, 0, C_MUL, 3, 0, 1'b0, 16'h000C);

    // Ignored inputs in ENTER_A, first-digit clear, digit beats operator.
    press_digit(4'd12);
    check("bad_digit hold", {16'd0, display_output}, 32'h000C);
    press_op(3'b101);
    check("bad_op state", {29'd0, tb_current_state}, 0);
    equal_input = 1'b1;
    tick();
    equal_input = 1'b0;
    check("equal_in_a state", {29'd0, tb_current_state}, 0);
    press_digit(4'd5);
    check("first_digit clear", {16'd0, display_output}, 32'h0005);
    press_op(C_NEG);
    check("toggle a", {16'd0, display_output}, 32'h8005);
    press_digit(4'd9);
    check("second digit", {16'd0, display_output}, 32'h803B);
    keypad_input   = 4'd1;
    read_input     = 1'b1;
    operator_input = C_ADD;
    tick();
    read_input     = 1'b0;
    operator_input = 3'b000;
    check("digit_over_op state", {29'd0, tb_current_state}, 0);
    check("digit_over_op display", {16'd0, display_output}, 32'h824F);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    check("entry_reset display", {16'd0, display_output}, 0);
    tick();

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      int unsigned an;
      int unsigned bn;
      int at;
      int bt;
      logic [2:0] code;
      logic [15:0] want;
      case ($urandom_range(0, 3))
        0:       an = $urandom_range(0, 9);
        1:       an = $urandom_range(0, 999);
        2:       an = $urandom_range(0, 40000);
        default: an = $urandom_range(0, 99999);
      endcase
      case ($urandom_range(0, 3))
        0:       bn = $urandom_range(0, 9);
        1:       bn = $urandom_range(0, 999);
        2:       bn = $urandom_range(0, 40000);
        default: bn = $urandom_range(0, 99999);
      endcase
      at = $urandom_range(0, 2);
      bt = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0:       code = C_ADD;
        1:       code = C_SUB;
        default: code = C_MUL;
      endcase
      want = model_result(operand_val(an, (at % 2) == 1),
                          operand_val(bn, (bt % 2) == 1), code);
      run_calc($sformatf("rnd%0d", i), an, at, code, bn, bt,
               bit'($urandom_range(0, 1)), want);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
